ps2_keymap_decoder: RTL and testbench

PS2_KEYMAP_DECODER -- requirements
Module: ps2_keymap_decoder

---
 rtl/ps2_keymap_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_keymap_decoder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keymap_decoder.sv
// -----------------------------------------------------------------------------
// ps2_keymap_decoder
//
// Turns the byte stream of a PS/2 keyboard (set-2 scancodes) into a held-key
// bitmap for a small music keyboard. Make codes press a key, F0-prefixed codes
// release it, and E0-prefixed (extended) codes are swallowed. A prefix that is
// never completed is abandoned after TIMEOUT_CYCLES quiet cycles.
//
// Ports
//   clk            clock, everything changes on its rising edge
//   reset          synchronous active-high reset
//   scancode       received byte, qualified by scancode_valid
//   scancode_valid one-cycle strobe per received byte
//   panic          synchronous all-notes-off
//   keys_held      bit i set while key i is held
//   key_count      number of bits set in keys_held
//   mono_key       one-hot last-pressed held key, zero when nothing is held
//   key_event      one-cycle pulse per accepted press or release
//   event_key      index of the changed key (valid with key_event)
//   event_press    1 = press, 0 = release (valid with key_event)
// -----------------------------------------------------------------------------
module ps2_keymap_decoder #(
   parameter int NUM_KEYS       = 18,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          scancode,
   input  logic                scancode_valid,
   input  logic                panic,
   output logic [NUM_KEYS-1:0] keys_held,
   output logic [4:0]          key_count,
   output logic [NUM_KEYS-1:0] mono_key,
   output logic                key_event,
   output logic [4:0]          event_key,
   output logic                event_press
);

   typedef logic [NUM_KEYS-1:0] kmask_t;
   typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;
   typedef struct packed {
      logic       hit;
      logic [4:0] idx;
   } lookup_t;

   localparam logic [7:0]  CODE_BRK = 8'hF0;
   localparam logic [7:0]  CODE_EXT = 8'hE0;
   localparam logic [25:0] TMO_LAST = 26'(TIMEOUT_CYCLES - 1);
   localparam logic [5:0]  NK       = 6'(NUM_KEYS);

   // Scancode to key index; codes beyond the configured key count are unmapped.
   function automatic lookup_t map_code(input logic [7:0] code);
      lookup_t r;
      r.hit = 1'b1;
      r.idx = 5'd0;
      case (code)
         8'h1C: r.idx = 5'd0;
         8'h1D: r.idx = 5'd1;
         8'h1B: r.idx = 5'd2;
         8'h24: r.idx = 5'd3;
         8'h23: r.idx = 5'd4;
         8'h2B: r.idx = 5'd5;
         8'h2C: r.idx = 5'd6;
         8'h34: r.idx = 5'd7;
         8'h35: r.idx = 5'd8;
         8'h33: r.idx = 5'd9;
         8'h3C: r.idx = 5'd10;
         8'h3B: r.idx = 5'd11;
         8'h42: r.idx = 5'd12;
         8'h44: r.idx = 5'd13;
         8'h4B: r.idx = 5'd14;
         8'h4D: r.idx = 5'd15;
         8'h4C: r.idx = 5'd16;
         8'h52: r.idx = 5'd17;
         default: r.hit = 1'b0;
      endcase
      if ({1'b0, r.idx} >= NK) r.hit = 1'b0;
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [25:0] tmo_q, tmo_d;
   kmask_t      keys_q, keys_d;
   logic [4:0]  count_q, count_d;
   kmask_t      mono_q, mono_d;
   logic [4:0]  last_q, last_d;
   logic        event_q, event_d;
   logic [4:0]  event_key_q, event_key_d;
   logic        event_press_q, event_press_d;

   lookup_t     lk;
   kmask_t      key_oh;
   kmask_t      last_oh;
   logic        key_is_held;
   logic        do_press;
   logic        do_release;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no path leaves it unassigned, which would infer a latch.
      lk            = map_code(scancode);
      key_oh        = kmask_t'(1) << lk.idx;
      key_is_held   = |(keys_q & key_oh);
      do_press      = 1'b0;
      do_release    = 1'b0;
      state_d       = state_q;
      tmo_d         = tmo_q;
      keys_d        = keys_q;
      last_d        = last_q;
      event_d       = 1'b0;
      event_key_d   = event_key_q;
      event_press_d = event_press_q;

      // Prefix parser and timeout. The counter only advances while a prefix
      // is pending; any received byte restarts it.
      if (scancode_valid) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (scancode == CODE_BRK)      state_d = ST_BRK;
               else if (scancode == CODE_EXT) state_d = ST_EXT;
               else                           do_press = lk.hit;
            end
            ST_BRK: begin
               if (lk.hit) begin
                  do_release = 1'b1;
                  state_d    = ST_IDLE;
               end else if (scancode != CODE_BRK && scancode != CODE_EXT) begin
                  state_d = ST_IDLE;
               end
            end
            ST_EXT:     state_d = (scancode == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
            ST_EXT_BRK: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         if (tmo_q == TMO_LAST) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + 26'd1;
         end
      end

      // Typematic repeats and releases of keys not held fall through silently.
      if (do_press && !key_is_held) begin
         keys_d        = keys_q | key_oh;
         last_d        = lk.idx;
         event_d       = 1'b1;
         event_key_d   = lk.idx;
         event_press_d = 1'b1;
      end
      if (do_release && key_is_held) begin
         keys_d        = keys_q & ~key_oh;
         event_d       = 1'b1;
         event_key_d   = lk.idx;
         event_press_d = 1'b0;
         // Releasing the mono note hands it to the lowest held key.
         if (lk.idx == last_q && keys_d != '0) begin
            for (int i = NUM_KEYS - 1; i >= 0; i--) begin
               if (keys_d[i]) last_d = 5'(i);
            end
         end
      end

      last_oh = kmask_t'(1) << last_d;
      mono_d  = (|(keys_d & last_oh)) ? last_oh : '0;

      count_d = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         count_d = count_d + 5'(keys_d[i]);
      end
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         tmo_q         <= '0;
         keys_q        <= '0;
         count_q       <= '0;
         mono_q        <= '0;
         last_q        <= '0;
         event_q       <= 1'b0;
         event_key_q   <= '0;
         event_press_q <= 1'b0;
      end else if (panic) begin
         // All-notes-off discards any coincident byte and any pending prefix.
         state_q <= ST_IDLE;
         tmo_q   <= '0;
         keys_q  <= '0;
         count_q <= '0;
         mono_q  <= '0;
         event_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         tmo_q         <= tmo_d;
         keys_q        <= keys_d;
         count_q       <= count_d;
         mono_q        <= mono_d;
         last_q        <= last_d;
         event_q       <= event_d;
         event_key_q   <= event_key_d;
         event_press_q <= event_press_d;
      end
   end

   assign keys_held   = keys_q;
   assign key_count   = count_q;
   assign mono_key    = mono_q;
   assign key_event   = event_q;
   assign event_key   = event_key_q;
   assign event_press = event_press_q;

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_keymap_decoder
//
// Two instances share one input stream: an 18-key decoder and an 8-key
// decoder, both with a 16-cycle prefix timeout. Directed vectors and corner
// sequences are checked against hand-derived constants; a random byte stream
// is then checked every cycle against a behavioural keyboard model.
// -----------------------------------------------------------------------------
module tb_ps2_keymap_decoder;

   localparam int TMO = 16;
   localparam logic [7:0] KEYMAP [18] = '{
      8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
      8'h33, 8'h3C, 8'h3B, 8'h42, 8'h44, 8'h4B, 8'h4D, 8'h4C, 8'h52
   };

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  scancode = 8'h00;
   logic        scancode_valid = 1'b0;
   logic        panic = 1'b0;

   logic [17:0] a_held, a_mono;
   logic [4:0]  a_count, a_evk;
   logic        a_ev, a_evp;
   logic [7:0]  b_held, b_mono;
   logic [4:0]  b_count, b_evk;
   logic        b_ev, b_evp;

   ps2_keymap_decoder #(.NUM_KEYS(18), .TIMEOUT_CYCLES(TMO)) dut18 (
      .clk(clk), .reset(reset), .scancode(scancode), .scancode_valid(scancode_valid),
      .panic(panic), .keys_held(a_held), .key_count(a_count), .mono_key(a_mono),
      .key_event(a_ev), .event_key(a_evk), .event_press(a_evp)
   );

   ps2_keymap_decoder #(.NUM_KEYS(8), .TIMEOUT_CYCLES(TMO)) dut8 (
      .clk(clk), .reset(reset), .scancode(scancode), .scancode_valid(scancode_valid),
      .panic(panic), .keys_held(b_held), .key_count(b_count), .mono_key(b_mono),
      .key_event(b_ev), .event_key(b_evk), .event_press(b_evp)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural keyboard model (index 0 = 18 keys, 1 = 8 keys)
   logic [17:0] m_held  [2];
   int          m_mono  [2];   // currently sounding mono key, -1 when silent
   bit          m_brk   [2];   // break prefix pending
   bit          m_ext   [2];   // extended prefix pending
   int          m_quiet [2];   // cycles without a byte since the last byte
   bit          m_ev    [2];
   int          m_evk   [2];
   bit          m_evp   [2];

   function automatic int lookup(input logic [7:0] c, input int nk);
      for (int i = 0; i < nk; i++) if (KEYMAP[i] == c) return i;
      return -1;
   endfunction

   function automatic int lowest_held(input logic [17:0] h);
      for (int i = 0; i < 18; i++) if (h[i]) return i;
      return -1;
   endfunction

   task automatic model_step(input bit r, input bit v, input logic [7:0] c, input bit p);
      for (int u = 0; u < 2; u++) begin
         int nk;
         int k;
         nk = (u == 0) ? 18 : 8;
         m_ev[u] = 1'b0;
         if (r) begin
            m_held[u] = '0; m_mono[u] = -1; m_brk[u] = 0; m_ext[u] = 0;
            m_quiet[u] = 0; m_evk[u] = 0; m_evp[u] = 0;
         end else if (p) begin
            m_held[u] = '0; m_mono[u] = -1; m_brk[u] = 0; m_ext[u] = 0; m_quiet[u] = 0;
         end else if (v) begin
            m_quiet[u] = 0;
            k = lookup(c, nk);
            if (m_ext[u]) begin
               // extended sequences never touch keys
               if (!m_brk[u] && c == 8'hF0) m_brk[u] = 1;
               else begin m_brk[u] = 0; m_ext[u] = 0; end
            end else if (m_brk[u]) begin
               if (k >= 0) begin
                  m_brk[u] = 0;
                  if (m_held[u][k]) begin
                     m_held[u][k] = 1'b0;
                     m_ev[u] = 1; m_evk[u] = k; m_evp[u] = 0;
                     if (m_mono[u] == k) m_mono[u] = lowest_held(m_held[u]);
                  end
               end else if (c != 8'hF0 && c != 8'hE0) begin
                  m_brk[u] = 0;
               end
            end else begin
               if (c == 8'hF0)      m_brk[u] = 1;
               else if (c == 8'hE0) m_ext[u] = 1;
               else if (k >= 0 && !m_held[u][k]) begin
                  m_held[u][k] = 1'b1;
                  m_mono[u] = k;
                  m_ev[u] = 1; m_evk[u] = k; m_evp[u] = 1;
               end
            end
         end else if (m_brk[u] || m_ext[u]) begin
            m_quiet[u]++;
            if (m_quiet[u] >= TMO) begin
               m_brk[u] = 0; m_ext[u] = 0; m_quiet[u] = 0;
            end
         end
      end
   endtask

   task automatic compare_model(input int cyc_no);
      logic [31:0] mono_exp;
      mono_exp = (m_mono[0] < 0) ? 32'd0 : (32'd1 << m_mono[0]);
      check($sformatf("rnd%0d held18", cyc_no), 32'(a_held), 32'(m_held[0]));
      check($sformatf("rnd%0d count18", cyc_no), 32'(a_count), 32'($countones(m_held[0])));
      check($sformatf("rnd%0d mono18", cyc_no), 32'(a_mono), mono_exp);
      check($sformatf("rnd%0d event18", cyc_no), 32'(a_ev), 32'(m_ev[0]));
      if (m_ev[0]) begin
         check($sformatf("rnd%0d evkey18", cyc_no), 32'(a_evk), 32'(m_evk[0]));
         check($sformatf("rnd%0d evpress18", cyc_no), 32'(a_evp), 32'(m_evp[0]));
      end
      mono_exp = (m_mono[1] < 0) ? 32'd0 : (32'd1 << m_mono[1]);
      check($sformatf("rnd%0d held8", cyc_no), 32'(b_held), 32'(m_held[1]));
      check($sformatf("rnd%0d count8", cyc_no), 32'(b_count), 32'($countones(m_held[1])));
      check($sformatf("rnd%0d mono8", cyc_no), 32'(b_mono), mono_exp);
      check($sformatf("rnd%0d event8", cyc_no), 32'(b_ev), 32'(m_ev[1]));
      if (m_ev[1]) begin
         check($sformatf("rnd%0d evkey8", cyc_no), 32'(b_evk), 32'(m_evk[1]));
         check($sformatf("rnd%0d evpress8", cyc_no), 32'(b_evp), 32'(m_evp[1]));
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
   task automatic cyc(input bit r, input bit v, input logic [7:0] c, input bit p);
      reset = r; scancode_valid = v; scancode = c; panic = p;
      @(posedge clk);
      model_step(r, v, c, p);
      #1;
   endtask

   task automatic expect18(input string n, input logic [17:0] held, input logic [4:0] cnt,
                           input logic [17:0] mono, input bit ev, input logic [4:0] evk,
                           input bit evp);
      check({n, " held"}, 32'(a_held), 32'(held));
      check({n, " count"}, 32'(a_count), 32'(cnt));
      check({n, " mono"}, 32'(a_mono), 32'(mono));
      check({n, " event"}, 32'(a_ev), 32'(ev));
      if (ev) begin
         check({n, " evkey"}, 32'(a_evk), 32'(evk));
         check({n, " evpress"}, 32'(a_evp), 32'(evp));
      end
   endtask

   // ---------------- directed vector table (18-key instance)
   typedef struct {
      bit          rst;
      bit          valid;
      logic [7:0]  code;
      logic [17:0] held;
      logic [4:0]  cnt;
      logic [17:0] mono;
      bit          ev;
      logic [4:0]  evk;
      bit          evp;
   } vec_t;

   function automatic vec_t mk(input bit rst, input bit valid, input logic [7:0] code,
                               input logic [17:0] held, input logic [4:0] cnt,
                               input logic [17:0] mono, input bit ev,
                               input logic [4:0] evk, input bit evp);
      vec_t t;
      t.rst = rst; t.valid = valid; t.code = code; t.held = held; t.cnt = cnt;
      t.mono = mono; t.ev = ev; t.evk = evk; t.evp = evp;
      return t;
   endfunction

   vec_t vecs[$];

   initial begin
      vecs.push_back(mk(1, 0, 8'h00, 18'h00000, 0, 18'h00000, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h1C, 18'h00001, 1, 18'h00001, 1, 0, 1));
      vecs.push_back(mk(0, 1, 8'h23, 18'h00011, 2, 18'h00010, 1, 4, 1));
      vecs.push_back(mk(0, 1, 8'h2B, 18'h00031, 3, 18'h00020, 1, 5, 1));
      vecs.push_back(mk(0, 1, 8'hF0, 18'h00031, 3, 18'h00020, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h2B, 18'h00011, 2, 18'h00001, 1, 5, 0));
      vecs.push_back(mk(0, 1, 8'h1C, 18'h00011, 2, 18'h00001, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h1C, 18'h00011, 2, 18'h00001, 0, 0, 0));
      vecs.push_back(mk(0, 0, 8'h1D, 18'h00011, 2, 18'h00001, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'hF0, 18'h00011, 2, 18'h00001, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h1C, 18'h00010, 1, 18'h00010, 1, 0, 0));
      vecs.push_back(mk(1, 0, 8'h00, 18'h00000, 0, 18'h00000, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'hE0, 18'h00000, 0, 18'h00000, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h1C, 18'h00000, 0, 18'h00000, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'hE0, 18'h00000, 0, 18'h00000, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'hF0, 18'h00000, 0, 18'h00000, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h1C, 18'h00000, 0, 18'h00000, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h1C, 18'h00001, 1, 18'h00001, 1, 0, 1));
      vecs.push_back(mk(0, 1, 8'hF0, 18'h00001, 1, 18'h00001, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'hF0, 18'h00001, 1, 18'h00001, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'hE0, 18'h00001, 1, 18'h00001, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h1C, 18'h00000, 0, 18'h00000, 1, 0, 0));
      vecs.push_back(mk(0, 1, 8'hF0, 18'h00000, 0, 18'h00000, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h1D, 18'h00000, 0, 18'h00000, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h1D, 18'h00002, 1, 18'h00002, 1, 1, 1));
      vecs.push_back(mk(0, 1, 8'hF0, 18'h00002, 1, 18'h00002, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h55, 18'h00002, 1, 18'h00002, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h1C, 18'h00003, 2, 18'h00001, 1, 0, 1));
      vecs.push_back(mk(0, 1, 8'h52, 18'h20003, 3, 18'h20000, 1, 17, 1));

      // Let the first edge see reset before anything else.
      cyc(1, 0, 8'h00, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].rst, vecs[i].valid, vecs[i].code, 0);
         expect18($sformatf("vec%0d", i), vecs[i].held, vecs[i].cnt, vecs[i].mono,
                  vecs[i].ev, vecs[i].evk, vecs[i].evp);
      end

      // Break prefix abandoned after exactly TMO quiet cycles: next code presses.
      cyc(1, 0, 8'h00, 0);
      cyc(0, 1, 8'hF0, 0);
      repeat (TMO) cyc(0, 0, 8'h00, 0);
      cyc(0, 1, 8'h1D, 0);
      expect18("timeout", 18'h00002, 1, 18'h00002, 1, 1, 1);

      // One cycle short of the timeout the prefix still applies.
      cyc(1, 0, 8'h00, 0);
      cyc(0, 1, 8'h1C, 0);
      cyc(0, 1, 8'hF0, 0);
      repeat (TMO - 1) cyc(0, 0, 8'h00, 0);
      cyc(0, 1, 8'h1C, 0);
      expect18("pre_timeout", 18'h00000, 0, 18'h00000, 1, 0, 0);

      // Reset between F0 and the key byte drops the prefix.
      cyc(0, 1, 8'hF0, 0);
      cyc(1, 0, 8'h00, 0);
      cyc(0, 1, 8'h1C, 0);
      expect18("rst_mid", 18'h00001, 1, 18'h00001, 1, 0, 1);

      // Reset coincident with a strobe wins.
      cyc(1, 1, 8'h1D, 0);
      expect18("rst_vs_byte", 18'h00000, 0, 18'h00000, 0, 0, 0);

      // 8-key instance: keys above index 7 are unmapped.
      cyc(1, 0, 8'h00, 0);
      cyc(0, 1, 8'h3C, 0);
      check("nk8 ignore event", 32'(b_ev), 32'd0);
      check("nk8 ignore held", 32'(b_held), 32'h00);
      cyc(0, 1, 8'h34, 0);
      check("nk8 held", 32'(b_held), 32'h80);
      check("nk8 count", 32'(b_count), 32'd1);
      check("nk8 mono", 32'(b_mono), 32'h80);
      check("nk8 event", 32'(b_ev), 32'd1);
      check("nk8 evkey", 32'(b_evk), 32'd7);
      check("nk8 evpress", 32'(b_evp), 32'd1);

      // Panic with a coincident byte: everything clears, byte discarded.
      cyc(1, 0, 8'h00, 0);
      cyc(0, 1, 8'h1C, 0);
      cyc(0, 1, 8'h52, 0);
      expect18("pre_panic", 18'h20001, 2, 18'h20000, 1, 17, 1);
      cyc(0, 1, 8'h24, 1);
      expect18("panic", 18'h00000, 0, 18'h00000, 0, 0, 0);
      cyc(0, 0, 8'h00, 0);
      expect18("post_panic", 18'h00000, 0, 18'h00000, 0, 0, 0);
      cyc(0, 1, 8'h24, 0);
      expect18("panic_idle", 18'h00008, 1, 18'h00008, 1, 3, 1);
      // Panic also drops a pending break prefix.
      cyc(0, 1, 8'hF0, 0);
      cyc(0, 0, 8'h00, 1);
      cyc(0, 1, 8'h24, 0);
      expect18("panic_prefix", 18'h00008, 1, 18'h00008, 1, 3, 1);

      // ---------------- random stream against the model
      cyc(1, 0, 8'h00, 0);
      compare_model(-1);
      for (int n = 0; n < 3000; n++) begin
         bit          v;
         bit          p;
         bit          r;
         int          pick;
         logic [7:0]  c;
         pick = int'($urandom_range(0, 99));
         if (pick < 35)      c = 8'hF0;
         else if (pick < 45) c = 8'hE0;
         else if (pick < 90) c = KEYMAP[$urandom_range(0, 17)];
         else                c = 8'($urandom_range(0, 255));
         v = ($urandom_range(0, 2) != 0);
         p = ($urandom_range(0, 79) == 0);
         r = ($urandom_range(0, 299) == 0);
         cyc(r, v, c, p);
         compare_model(n);
         if ($urandom_range(0, 29) == 0) begin
            int gap;
            gap = int'($urandom_range(12, 20));
            for (int g = 0; g < gap; g++) begin
               cyc(0, 0, 8'($urandom_range(0, 255)), 0);
               compare_model(n);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
